// File: rtl/seed_expand_if.sv
// Hash-engine and seed-memory bus of seed_expand.
// master: seed_expand side. It drives the hash request, the message and the
//         seed-memory write port. It receives hash_done and hash_data_out.
// slave : hash engine / seed memory side.
interface seed_expand_if #(
    parameter int unsigned WOTS_LEN = 67,
    parameter int unsigned KEY_LEN  = 256
);
    localparam int unsigned ADDR_W = (WOTS_LEN > 1) ? $clog2(WOTS_LEN) : 1;

    logic                hash_start;
    logic [1023:0]       hash_data_in;
    logic                message_length;
    logic                store_intermediate;
    logic                continue_intermediate;
    logic                hash_done;
    logic [KEY_LEN-1:0]  hash_data_out;
    logic                seed_mem_wr_en;
    logic [ADDR_W-1:0]   seed_mem_wr_addr;
    logic [KEY_LEN-1:0]  seed_mem_wr_data;

    modport master (
        output hash_start, hash_data_in, message_length,
               store_intermediate, continue_intermediate,
               seed_mem_wr_en, seed_mem_wr_addr, seed_mem_wr_data,
        input  hash_done, hash_data_out
    );

    modport slave (
        input  hash_start, hash_data_in, message_length,
               store_intermediate, continue_intermediate,
               seed_mem_wr_en, seed_mem_wr_addr, seed_mem_wr_data,
        output hash_done, hash_data_out
    );
endinterface

// File: rtl/seed_expand.sv
// Expands a secret seed into WOTS_LEN chain seeds: seed_i = PRF(sec_seed, toByte(i,32)).
// Each seed is written to seed memory at address i.
// Ports:
//   clk, reset     - clock and asynchronous active-low reset
//   start/sec_seed - one-cycle request and the seed, latched on acceptance
//   busy/done      - busy during the expansion; done is a one-cycle completion pulse
//   hif (master)   - hash request/response and seed-memory write port
module seed_expand #(
    parameter int unsigned WOTS_LEN              = 67,
    parameter int unsigned KEY_LEN               = 256,
    parameter int unsigned XMSS_HASH_PADDING_PRF = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_LEN-1:0] sec_seed,
    output logic               busy,
    output logic               done,
    seed_expand_if.master      hif
);
    localparam int unsigned ADDR_W   = (WOTS_LEN > 1) ? $clog2(WOTS_LEN) : 1;
    localparam int unsigned TOBYTE_W = 256;
    localparam int unsigned HASH_W   = 1024;
    localparam int unsigned MSG_W    = 2 * TOBYTE_W + KEY_LEN;
    localparam int unsigned PAD_W    = HASH_W - MSG_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WOTS_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [KEY_LEN-1:0] seed_q, seed_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hstart_q, hstart_d;
    logic               store_q, store_d;
    logic               cont_q, cont_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [KEY_LEN-1:0] wr_data_q, wr_data_d;

    // State, index, latched seed and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seed_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hstart_q  <= 1'b0;
            store_q   <= 1'b0;
            cont_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seed_q    <= seed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hstart_q  <= hstart_d;
            store_q   <= store_d;
            cont_q    <= cont_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next state. Outputs are decoded from the next state so that they are
    // registered and still line up with the state they belong to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seed_d    = seed_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    seed_d  = sec_seed;
                end
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                // The hash result is captured directly into the write-data register
                if (hif.hash_done) begin
                    state_d   = WRITE;
                    wr_data_d = hif.hash_data_out;
                end
            end
            WRITE: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    state_d = REQ;
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d == REQ) || (state_d == WAIT) || (state_d == WRITE);
        done_d   = (state_d == FIN);
        hstart_d = (state_d == REQ);
        wr_en_d  = (state_d == WRITE);
        // The first request stores the first-block state. Later requests resume from it.
        store_d  = ((state_d == REQ) || (state_d == WAIT)) && (cnt_d == '0);
        cont_d   = ((state_d == REQ) || (state_d == WAIT)) && (cnt_d != '0);
        if (state_d == WRITE) begin
            wr_addr_d = cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    assign hif.hash_start            = hstart_q;
    assign hif.store_intermediate    = store_q;
    assign hif.continue_intermediate = cont_q;
    assign hif.message_length        = 1'b0;
    // Message: {toByte(PRF,32), seed, toByte(i,32)}, left-aligned, zero tail
    assign hif.hash_data_in = {TOBYTE_W'(XMSS_HASH_PADDING_PRF), seed_q,
                               TOBYTE_W'(cnt_q), {PAD_W{1'b0}}};
    assign hif.seed_mem_wr_en   = wr_en_q;
    assign hif.seed_mem_wr_addr = wr_addr_q;
    assign hif.seed_mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_seed_expand.sv
// Bench for seed_expand: a behavioural hash engine plus a scoreboard of expected seed writes.
module tb_seed_expand;
    localparam int unsigned WOTS_LEN = 67;
    localparam int unsigned KEY_LEN  = 256;
    localparam int unsigned PRF_C    = 3;
    localparam int unsigned ADDR_W   = $clog2(WOTS_LEN);

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [KEY_LEN-1:0] data;
    } wr_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [KEY_LEN-1:0] sec_seed;
    logic               busy;
    logic               done;

    int          n_vec;
    int          n_bad;
    int          lat;
    bit          inject_now;
    bit          inject_wr;
    int          done_cnt;
    int          wr_total;
    int          exp_req_i;
    logic [255:0] cur_seed;
    wr_t         sb_q[$];

    seed_expand_if #(.WOTS_LEN(WOTS_LEN), .KEY_LEN(KEY_LEN)) hif();

    seed_expand #(
        .WOTS_LEN(WOTS_LEN),
        .KEY_LEN(KEY_LEN),
        .XMSS_HASH_PADDING_PRF(PRF_C)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .start(start),
        .sec_seed(sec_seed),
        .busy(busy),
        .done(done),
        .hif(hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Stand-in for the PRF hash: an arbitrary fixed mixing of the whole message
    function automatic logic [255:0] mix(input logic [1023:0] m);
        logic [255:0] a, b, c, d;
        a = m[1023:768];
        b = m[767:512];
        c = m[511:256];
        d = m[255:0];
        return (a * 256'd3141592653589793) ^ {b[242:0], b[255:243]} ^
               (c * 256'h9E3779B97F4A7C15F39CC0605CEDC835) ^ d ^ {b[127:0], c[255:128]};
    endfunction

    function automatic logic [1023:0] ref_msg(input logic [255:0] seed, input int i);
        return {256'(PRF_C), seed, 256'(unsigned'(i)), 256'd0};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural hash engine: answers each request lat+1 cycles later
    initial begin : hash_model
        int           cnt;
        bit           pend;
        logic [1023:0] held;
        logic          held_st;
        logic          held_ct;
        pend = 0;
        cnt = 0;
        held = '0;
        held_st = 0;
        held_ct = 0;
        hif.hash_done = 1'b0;
        hif.hash_data_out = '0;
        forever begin
            @(negedge clk);
            hif.hash_done = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 0;
                    if (busy) begin
                        chk("msg_stable", 256'(hif.hash_data_in == held &&
                            hif.store_intermediate == held_st &&
                            hif.continue_intermediate == held_ct), 256'(1));
                    end
                    hif.hash_done = 1'b1;
                    hif.hash_data_out = mix(held);
                end
            end
            if (inject_now || (inject_wr && hif.seed_mem_wr_en)) begin
                hif.hash_done = 1'b1;
                hif.hash_data_out = rand256();
            end
            if (rst_n && hif.hash_start) begin
                pend = 1;
                cnt = lat + 1;
                held = hif.hash_data_in;
                held_st = hif.store_intermediate;
                held_ct = hif.continue_intermediate;
            end
        end
    end

    // Request monitor: message fields and first/continue flags
    always @(negedge clk) begin
        if (rst_n && hif.hash_start) begin
            chk("req_prf",   hif.hash_data_in[1023:768], 256'(PRF_C));
            chk("req_seed",  hif.hash_data_in[767:512], cur_seed);
            chk("req_index", hif.hash_data_in[511:256], 256'(unsigned'(exp_req_i)));
            chk("req_tail",  hif.hash_data_in[255:0], 256'd0);
            chk("req_len",   256'(hif.message_length), 256'd0);
            chk("req_store", 256'(hif.store_intermediate), 256'(exp_req_i == 0));
            chk("req_cont",  256'(hif.continue_intermediate), 256'(exp_req_i != 0));
            exp_req_i++;
        end
    end

    // Write monitor: pops the scoreboard on every seed-memory write
    always @(negedge clk) begin
        if (rst_n && hif.seed_mem_wr_en) begin
            wr_total++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write addr=%0d", hif.seed_mem_wr_addr);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_addr", 256'(hif.seed_mem_wr_addr), 256'(e.addr));
                chk("wr_data", hif.seed_mem_wr_data, e.data);
            end
        end
    end

    // Done monitor: busy must already be low in the done cycle
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            chk("done_busy", 256'(busy), 256'd0);
        end
    end

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"},   256'(busy), 256'd0);
        chk({tag, "_done"},   256'(done), 256'd0);
        chk({tag, "_hstart"}, 256'(hif.hash_start), 256'd0);
        chk({tag, "_store"},  256'(hif.store_intermediate), 256'd0);
        chk({tag, "_cont"},   256'(hif.continue_intermediate), 256'd0);
        chk({tag, "_wr_en"},  256'(hif.seed_mem_wr_en), 256'd0);
        chk({tag, "_wr_addr"}, 256'(hif.seed_mem_wr_addr), 256'd0);
        chk({tag, "_wr_data"}, hif.seed_mem_wr_data, 256'd0);
        chk({tag, "_msg_hi"}, hif.hash_data_in[1023:768], 256'(PRF_C));
        chk({tag, "_msg_seed"}, hif.hash_data_in[767:512], 256'd0);
        chk({tag, "_msg_idx"}, hif.hash_data_in[511:256], 256'd0);
    endtask

    // Drive a start at a negedge and load the expected writes into the scoreboard
    task automatic issue_start(input logic [255:0] seed);
        start = 1'b1;
        sec_seed = seed;
        cur_seed = seed;
        exp_req_i = 0;
        for (int i = 0; i < int'(WOTS_LEN); i++) begin
            wr_t e;
            e.addr = ADDR_W'(i);
            e.data = mix(ref_msg(seed, i));
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        sec_seed = rand256();
    endtask

    task automatic wait_done(output int cyc);
        bit found;
        cyc = 0;
        found = 0;
        for (int k = 0; k < 5000; k++) begin
            if (busy || done) cyc++;
            if (done) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout got=none exp=done");
        end
    endtask

    task automatic finish_checks();
        repeat (3) @(negedge clk);
        chk("sb_empty", 256'(sb_q.size()), 256'd0);
        chk("idle_busy", 256'(busy), 256'd0);
    endtask

    task automatic run_full(input logic [255:0] seed, input int l, output int cyc);
        int d0;
        d0 = done_cnt;
        lat = l;
        issue_start(seed);
        wait_done(cyc);
        finish_checks();
        chk("done_pulses", 256'(done_cnt - d0), 256'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int d0;
        int w0;
        bit found;
        n_vec = 0;
        n_bad = 0;
        done_cnt = 0;
        wr_total = 0;
        exp_req_i = 0;
        cur_seed = '0;
        lat = 10;
        inject_now = 0;
        inject_wr = 0;
        start = 1'b0;
        sec_seed = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cleared("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero seed, 10-cycle hash latency
        run_full('0, 10, cyc);

        // All-ones seed, random short latency
        run_full('1, int'($urandom_range(1, 4)), cyc);

        // Spurious hash_done while idle
        w0 = wr_total;
        inject_now = 1;
        repeat (3) @(negedge clk);
        inject_now = 0;
        repeat (3) @(negedge clk);
        chk("spur_idle_busy", 256'(busy), 256'd0);
        chk("spur_idle_writes", 256'(wr_total - w0), 256'd0);

        // Spurious hash_done during every write cycle
        inject_wr = 1;
        run_full(rand256(), 2, cyc);
        inject_wr = 0;

        // Re-start at write 5 with another seed must be ignored
        d0 = done_cnt;
        lat = 3;
        issue_start(rand256());
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            if (hif.seed_mem_wr_en && hif.seed_mem_wr_addr == ADDR_W'(5)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("restart_seen_w5", 256'(found), 256'd1);
        start = 1'b1;
        sec_seed = rand256();
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        finish_checks();
        chk("restart_done_pulses", 256'(done_cnt - d0), 256'd1);

        // Reset during WAIT at i = 20, outstanding hash_done afterwards
        lat = 10;
        issue_start(rand256());
        found = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hif.hash_start && hif.hash_data_in[287:256] == 32'd20) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_seen_i20", 256'(found), 256'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_cleared("abort");
        sb_q.delete();
        w0 = wr_total;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_writes", 256'(wr_total - w0), 256'd0);
        run_full(rand256(), int'($urandom_range(1, 6)), cyc);

        // Back-to-back hash: 4 cycles per seed plus the done cycle
        run_full(rand256(), 1, cyc);
        chk("runtime", 256'(cyc), 256'(WOTS_LEN * 4 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
